// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A/D channel bundle between a single initiator (master) and a responder (slave).
interface tl_ul_sram_responder_if;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
    input  a_ready, d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
    output a_ready, d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL Get/Put responder over a word-wide single-port SRAM with a two-deep response queue.
// Define TL_RESP_WRITE_EN to enable Puts; otherwise ROM-like.
module tl_ul_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input logic                   cpu_clk_i,
  input logic                   cpu_rst_n_i,
  tl_ul_sram_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        ack_data;
    logic [3:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } resp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rdata;
  resp_t         resp_q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;
  logic          pend_valid;
  logic          pend_idx;

  logic          can_accept;
  logic          has_resp;
  logic          a_fire;
  logic          d_fire;
  logic          is_put;
  logic          legal_op;
  logic          misaligned;
  logic          out_of_range;
  logic          mask_bad;
  logic          denied;
  logic          good_get;
  logic [3:0]    natural_mask;
  logic [AW-1:0] word_idx;
  resp_t         new_resp;
  resp_t         head;
  logic          unused_inputs;

  assign unused_inputs = ^{bus.a_param, bus.a_data};

  assign can_accept = (occ != 2'd2);
  assign has_resp   = (occ != 2'd0);
  assign a_fire     = bus.a_valid && can_accept;
  assign d_fire     = has_resp && bus.d_ready;
  assign word_idx   = bus.a_address[AW+1:2];

  always_comb begin
    is_put       = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
    legal_op     = is_put || (bus.a_opcode == 3'd4);
    misaligned   = 1'b0;
    natural_mask = 4'hF;
    case (bus.a_size)
      4'd0: natural_mask = 4'b0001 << bus.a_address[1:0];
      4'd1: begin
        misaligned   = bus.a_address[0];
        natural_mask = 4'b0011 << bus.a_address[1:0];
      end
      4'd2: misaligned = |bus.a_address[1:0];
      default: ;
    endcase
    // BASE_ADDR is aligned to the window size, so only the bits above the window need to match
    out_of_range = bus.a_address[31:AW+2] != BASE_ADDR[31:AW+2];
    mask_bad     = (bus.a_opcode == 3'd0) && (bus.a_mask != natural_mask);
    denied       = !legal_op || (bus.a_size > 4'd2) || misaligned || out_of_range ||
                   mask_bad || (is_put && bus.a_corrupt);
`ifndef TL_RESP_WRITE_EN
    denied       = denied || is_put;
`endif
  end

  assign good_get = a_fire && !is_put && !denied;

  always_comb begin
    new_resp          = '0;
    new_resp.ack_data = !is_put;
    new_resp.size     = bus.a_size;
    new_resp.denied   = denied;
    new_resp.corrupt  = !is_put && denied;
  end

`ifdef TL_RESP_WRITE_EN
  logic good_put;
  assign good_put = a_fire && is_put && !denied;
`endif

  always_ff @(posedge cpu_clk_i) begin
    if (good_get) rdata <= mem[word_idx];
`ifdef TL_RESP_WRITE_EN
    for (int b = 0; b < 4; b++) begin
      if (good_put && bus.a_mask[b]) mem[word_idx][8*b +: 8] <= bus.a_data[8*b +: 8];
    end
`endif
  end

  // Read data lands in its queue slot one cycle after the fire; pend_* tracks that slot.
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
    if (!cpu_rst_n_i) begin
      resp_q[0]  <= '0;
      resp_q[1]  <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      pend_valid <= 1'b0;
      pend_idx   <= 1'b0;
    end else begin
      if (pend_valid) resp_q[pend_idx].data <= rdata;
      if (a_fire) begin
        resp_q[wr_ptr] <= new_resp;
        wr_ptr         <= !wr_ptr;
      end
      if (d_fire) rd_ptr <= !rd_ptr;
      pend_valid <= good_get;
      pend_idx   <= wr_ptr;
      case ({a_fire, d_fire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    head = resp_q[rd_ptr];
    if (pend_valid && (pend_idx == rd_ptr)) head.data = rdata;
    if (!has_resp) head = '0;
  end

  assign bus.a_ready   = can_accept;
  assign bus.d_valid   = has_resp;
  assign bus.d_opcode  = {2'b00, head.ack_data};
  assign bus.d_param   = 2'b00;
  assign bus.d_size    = head.size;
  assign bus.d_denied  = head.denied;
  assign bus.d_corrupt = head.corrupt;
  assign bus.d_data    = head.data;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Bench for tl_ul_sram_responder: directed steps, then random traffic scored against a queue/array model.
module tb_tl_ul_sram_responder;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } resp_t;

  logic cpu_clk_i = 1'b0;
  logic cpu_rst_n_i;

  tl_ul_sram_responder_if bus();

  tl_ul_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .cpu_clk_i  (cpu_clk_i),
    .cpu_rst_n_i(cpu_rst_n_i),
    .bus        (bus)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  resp_t       exp_q [$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: every response follows directly from the request fields and the model memory.
  task automatic modelRequest(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                              input logic [3:0] msk, input logic [31:0] dat, input logic cor);
    resp_t      r;
    longint     offset;
    int         idx;
    logic [3:0] nat;
    bit         is_put, legal, aligned, in_range, denied;
    offset   = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    is_put   = (op == 3'd0) || (op == 3'd1);
    legal    = is_put || (op == 3'd4);
    in_range = (offset >= 0) && (offset < longint'(4 * DEPTH));
    aligned  = 1'b1;
    nat      = 4'hF;
    if (sz <= 4'd2) begin
      aligned = (addr % (32'd1 << sz)) == 32'd0;
      nat     = 4'(((32'd1 << (32'd1 << sz)) - 32'd1) << addr[1:0]);
    end
    denied = !legal || (sz > 4'd2) || !aligned || !in_range ||
             ((op == 3'd0) && (msk != nat)) || (is_put && cor);
`ifndef TL_RESP_WRITE_EN
    denied = denied || is_put;
`endif
    idx       = int'(offset / 4);
    r.size    = sz;
    r.denied  = denied;
    r.data    = 32'h0;
    if (is_put) begin
      r.opcode  = 3'd0;
      r.corrupt = 1'b0;
      if (!denied) begin
        for (int b = 0; b < 4; b++)
          if (msk[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end
    end else begin
      r.opcode  = 3'd1;
      r.corrupt = denied;
      if (!denied) r.data = model_mem[idx];
    end
    exp_q.push_back(r);
  endtask

  task automatic checkOutput();
    checkVal("a_ready", 32'(bus.a_ready), 32'(exp_q.size() < 2));
    checkVal("d_valid", 32'(bus.d_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkVal("d_opcode",  32'(bus.d_opcode),  32'(exp_q[0].opcode));
      checkVal("d_param",   32'(bus.d_param),   32'd0);
      checkVal("d_size",    32'(bus.d_size),    32'(exp_q[0].size));
      checkVal("d_denied",  32'(bus.d_denied),  32'(exp_q[0].denied));
      checkVal("d_corrupt", 32'(bus.d_corrupt), 32'(exp_q[0].corrupt));
      checkVal("d_data",    bus.d_data,         exp_q[0].data);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [2:0] op, input logic [3:0] sz,
                               input logic [31:0] addr, input logic [3:0] msk,
                               input logic [31:0] dat, input logic cor, input logic dr);
    bit a_fire, d_fire;
    bus.a_valid   = av;
    bus.a_opcode  = op;
    bus.a_param   = 3'($urandom_range(0, 7));
    bus.a_size    = sz;
    bus.a_address = addr;
    bus.a_mask    = msk;
    bus.a_data    = dat;
    bus.a_corrupt = cor;
    bus.d_ready   = dr;
    a_fire = av && (exp_q.size() < 2);
    d_fire = dr && (exp_q.size() != 0);
    if (d_fire) void'(exp_q.pop_front());
    if (a_fire) modelRequest(op, sz, addr, msk, dat, cor);
    @(posedge cpu_clk_i);
    #1;
  endtask

  task automatic runCycle(input logic av, input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] addr, input logic [3:0] msk,
                          input logic [31:0] dat, input logic cor, input logic dr);
    checkOutput();
    applyStimulus(av, op, sz, addr, msk, dat, cor, dr);
  endtask

  task automatic getCycle(input logic [31:0] addr, input logic dr);
    runCycle(1'b1, 3'd4, 4'd2, addr, 4'hF, 32'h0, 1'b0, dr);
  endtask

  task automatic drainQueue();
    for (int n = 0; n < 4; n++)
      if (exp_q.size() != 0) runCycle(1'b0, 3'd4, 4'd2, BASE, 4'hF, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic randomCycle();
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [31:0] addr;
    logic [3:0]  msk;
    int unsigned pick, word, lane;
    pick = $urandom_range(0, 19);
    if (pick < 9)       op = 3'd4;
    else if (pick < 13) op = 3'd0;
    else if (pick < 18) op = 3'd1;
    else if (pick == 18) op = 3'($urandom_range(2, 3));
    else                op = 3'($urandom_range(5, 7));
    sz   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
    word = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 15);
    lane = $urandom_range(0, 3);
    if (sz <= 4'd2 && $urandom_range(0, 11) != 0) lane = lane - (lane % (32'd1 << sz));
    addr = BASE + 32'(word * 4 + lane);
    case ($urandom_range(0, 15))
      0:       addr = BASE + 32'(4 * DEPTH + lane);
      1:       addr = BASE - 32'd4;
      default: ;
    endcase
    if (op == 3'd0 && sz <= 4'd2 && $urandom_range(0, 9) != 0)
      msk = 4'(((32'd1 << (32'd1 << sz)) - 32'd1) << lane);
    else
      msk = 4'($urandom_range(0, 15));
    runCycle($urandom_range(0, 9) < 7, op, sz, addr, msk, $urandom(),
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
  endtask

  initial begin
    bus.a_valid   = 1'b0;
    bus.a_opcode  = 3'd4;
    bus.a_param   = 3'd0;
    bus.a_size    = 4'd2;
    bus.a_address = BASE;
    bus.a_mask    = 4'hF;
    bus.a_data    = 32'h0;
    bus.a_corrupt = 1'b0;
    bus.d_ready   = 1'b0;
    cpu_rst_n_i   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = $urandom();
      dut.mem[i]   = model_mem[i];
    end
    model_mem[4] = 32'hDEADBEEF;
    dut.mem[4]   = 32'hDEADBEEF;
    $display("[TB] reset and preload done");

    repeat (3) @(posedge cpu_clk_i);
    #1;
    checkVal("rst_hold_d_valid", 32'(bus.d_valid), 32'd0);
    @(negedge cpu_clk_i);
    cpu_rst_n_i = 1'b1;
    @(posedge cpu_clk_i);
    #1;
    checkVal("rst_a_ready",   32'(bus.a_ready),   32'd1);
    checkVal("rst_d_valid",   32'(bus.d_valid),   32'd0);
    checkVal("rst_d_opcode",  32'(bus.d_opcode),  32'd0);
    checkVal("rst_d_param",   32'(bus.d_param),   32'd0);
    checkVal("rst_d_size",    32'(bus.d_size),    32'd0);
    checkVal("rst_d_denied",  32'(bus.d_denied),  32'd0);
    checkVal("rst_d_data",    bus.d_data,         32'd0);
    checkVal("rst_d_corrupt", 32'(bus.d_corrupt), 32'd0);

    getCycle(BASE + 32'h10, 1'b1);
    checkVal("get_latency_valid", 32'(bus.d_valid), 32'd1);
    checkVal("get_preload_data",  bus.d_data,        32'hDEADBEEF);
    runCycle(1'b1, 3'd1, 4'd2, BASE + 32'h10, 4'b0010, 32'h0000AA00, 1'b0, 1'b1);
    getCycle(BASE + 32'h10, 1'b1);
`ifdef TL_RESP_WRITE_EN
    checkVal("put_partial_merge", bus.d_data, 32'hDEADAAEF);
`else
    checkVal("rom_put_no_write",  bus.d_data, 32'hDEADBEEF);
`endif
    getCycle(BASE + 32'(4 * DEPTH), 1'b1);
    checkVal("oob_denied",  32'(bus.d_denied),  32'd1);
    checkVal("oob_corrupt", 32'(bus.d_corrupt), 32'd1);
    checkVal("oob_data",    bus.d_data,         32'd0);
    runCycle(1'b1, 3'd4, 4'd3, BASE + 32'h10, 4'hF, 32'h0, 1'b0, 1'b1);
    checkVal("size3_denied", 32'(bus.d_denied), 32'd1);
    drainQueue();

    $display("[TB] backpressure");
    getCycle(BASE + 32'h20, 1'b0);
    getCycle(BASE + 32'h24, 1'b0);
    getCycle(BASE + 32'h28, 1'b0);
    checkVal("bp_a_ready_low", 32'(bus.a_ready), 32'd0);
    getCycle(BASE + 32'h28, 1'b1);
    checkVal("bp_a_ready_back", 32'(bus.a_ready), 32'd1);
    getCycle(BASE + 32'h28, 1'b1);
    drainQueue();

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) getCycle(BASE + 32'(4 * (8 + i)), 1'b1);
    drainQueue();

    $display("[TB] reset with full queue");
    getCycle(BASE + 32'h30, 1'b0);
    getCycle(BASE + 32'h34, 1'b0);
    checkOutput();
    bus.a_valid = 1'b0;
    #2;
    cpu_rst_n_i = 1'b0;
    #1;
    checkVal("mid_rst_d_valid", 32'(bus.d_valid), 32'd0);
    exp_q.delete();
    @(negedge cpu_clk_i);
    cpu_rst_n_i = 1'b1;
    @(posedge cpu_clk_i);
    #1;
    checkVal("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 3'd4, 4'd2, BASE, 4'hF, 32'h0, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) randomCycle();
    drainQueue();
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
